// File: rtl/io_mmio_bank_if.sv
// -----------------------------------------------------------------------------
// io_mmio_bank_if
// Load/store bus between the core and the memory-mapped I/O bank.
//   en_store / addr_store / data_store : store request from the core
//   en_load  / addr_load               : load request from the core
//   data_load                          : load data returned by the bank
//   mem_en_load / mem_en_store         : request forwarded to data memory
//                                        when the address misses the window
// Modports: master = core side, slave = I/O bank side.
// -----------------------------------------------------------------------------
interface io_mmio_bank_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              en_store;
    logic [ADDR_W-1:0] addr_store;
    logic [DATA_W-1:0] data_store;
    logic              en_load;
    logic [ADDR_W-1:0] addr_load;
    logic [DATA_W-1:0] data_load;
    logic              mem_en_load;
    logic              mem_en_store;

    modport master (
        output en_store, addr_store, data_store, en_load, addr_load,
        input  data_load, mem_en_load, mem_en_store
    );

    modport slave (
        input  en_store, addr_store, data_store, en_load, addr_load,
        output data_load, mem_en_load, mem_en_store
    );
endinterface

// File: rtl/io_mmio_bank.sv
// -----------------------------------------------------------------------------
// io_mmio_bank
// Memory-mapped I/O bank sitting between the core load/store path and data
// memory. A window of 4*N_PORTS words starting at BASE_ADDR is decoded here;
// anything outside is forwarded to memory via mem_en_load / mem_en_store.
// Each port has four registers:
//   +0 OUT    (RW)  drives io_output
//   +1 IN     (RO)  synchronised io_input
//   +2 EDGE   (R/W1C) sticky edge-capture status
//   +3 IRQ_EN (RW)  per-bit interrupt mask
// Ports:
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   bus         : load/store bus (slave modport)
//   io_input    : asynchronous external inputs, port p at [p*DATA_W +: DATA_W]
//   io_output   : OUT registers, same packing
//   irq         : registered OR over ports of (EDGE & IRQ_EN)
// -----------------------------------------------------------------------------
module io_mmio_bank #(
    parameter int                ADDR_W      = 10,
    parameter int                DATA_W      = 8,
    parameter int                N_PORTS     = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 10'h3F0,
    parameter int                SYNC_STAGES = 2,
    parameter int                EDGE_MODE   = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    io_mmio_bank_if.slave               bus,
    input  logic [N_PORTS*DATA_W-1:0]   io_input,
    output logic [N_PORTS*DATA_W-1:0]   io_output,
    output logic                        irq
);

    localparam int                PW        = N_PORTS * DATA_W;
    localparam int                IDX_W     = ADDR_W - 2;
    localparam logic [ADDR_W-1:0] WIN_WORDS = ADDR_W'(4 * N_PORTS);

    // Register offsets inside a port's 4-word block
    localparam logic [1:0] REG_OUT    = 2'd0;
    localparam logic [1:0] REG_IN     = 2'd1;
    localparam logic [1:0] REG_EDGE   = 2'd2;
    localparam logic [1:0] REG_IRQ_EN = 2'd3;

    // Decode signals
    logic [ADDR_W-1:0]  st_off_s;
    logic [ADDR_W-1:0]  ld_off_s;
    logic               st_in_win_s;
    logic               ld_in_win_s;
    logic [IDX_W-1:0]   st_idx_s;
    logic [IDX_W-1:0]   ld_idx_s;
    logic [1:0]         st_reg_s;
    logic [1:0]         ld_reg_s;
    logic [N_PORTS-1:0] st_sel_s;
    logic [N_PORTS-1:0] ld_sel_s;

    // Per-port write strobes
    logic [N_PORTS-1:0] wr_out_s;
    logic [N_PORTS-1:0] wr_edge_s;
    logic [N_PORTS-1:0] wr_irq_en_s;

    // State
    logic [PW-1:0]      sync_r [SYNC_STAGES];
    logic [PW-1:0]      prev_r;
    logic [PW-1:0]      out_r;
    logic [PW-1:0]      edge_r;
    logic [PW-1:0]      irq_en_r;
    logic               irq_r;

    // Datapath
    logic [PW-1:0]      in_s;
    logic [PW-1:0]      rise_s;
    logic [PW-1:0]      fall_s;
    logic [PW-1:0]      new_edge_s;
    logic [PW-1:0]      edge_nxt_s;
    logic [DATA_W-1:0]  port_rd_s [N_PORTS];
    logic [DATA_W-1:0]  data_load_s;

    assign in_s = sync_r[SYNC_STAGES-1];

    // Address decode for load and store; the two paths are independent
    always_comb begin
        st_off_s    = bus.addr_store - BASE_ADDR;
        ld_off_s    = bus.addr_load - BASE_ADDR;
        // The >= test rejects addresses below BASE whose offset wrapped around
        st_in_win_s = (bus.addr_store >= BASE_ADDR) && (st_off_s < WIN_WORDS);
        ld_in_win_s = (bus.addr_load >= BASE_ADDR) && (ld_off_s < WIN_WORDS);
        st_idx_s    = st_off_s[ADDR_W-1:2];
        ld_idx_s    = ld_off_s[ADDR_W-1:2];
        st_reg_s    = st_off_s[1:0];
        ld_reg_s    = ld_off_s[1:0];
    end

    // One-hot port select for each access path
    always_comb begin
        st_sel_s = '0;
        ld_sel_s = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            st_sel_s[p] = bus.en_store && st_in_win_s && (st_idx_s == IDX_W'(p));
            ld_sel_s[p] = bus.en_load && ld_in_win_s && (ld_idx_s == IDX_W'(p));
        end
    end

    // Store strobes per register; writes to IN are dropped
    always_comb begin
        wr_out_s    = '0;
        wr_edge_s   = '0;
        wr_irq_en_s = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            case (st_reg_s)
                REG_OUT:    wr_out_s[p]    = st_sel_s[p];
                REG_IN:     wr_out_s[p]    = 1'b0;
                REG_EDGE:   wr_edge_s[p]   = st_sel_s[p];
                REG_IRQ_EN: wr_irq_en_s[p] = st_sel_s[p];
                default:    wr_out_s[p]    = 1'b0;
            endcase
        end
    end

    // Memory fallback strobes
    assign bus.mem_en_store = bus.en_store && !st_in_win_s;
    assign bus.mem_en_load  = bus.en_load && !ld_in_win_s;

    // Input synchroniser chain; reset to 0 so a pin held high through reset
    // shows up as a rising edge once reset is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= io_input;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Previous sample of IN for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= '0;
        end else begin
            prev_r <= in_s;
        end
    end

    // Edge selection according to the build-time mode
    always_comb begin
        rise_s     = in_s & ~prev_r;
        fall_s     = ~in_s & prev_r;
        new_edge_s = '0;
        case (EDGE_MODE)
            32'sd0:  new_edge_s = rise_s;
            32'sd1:  new_edge_s = fall_s;
            32'sd2:  new_edge_s = rise_s | fall_s;
            default: new_edge_s = rise_s;
        endcase
    end

    // EDGE next value: write-1-to-clear, with a freshly detected edge winning
    // over a same-cycle clear of that bit
    always_comb begin
        edge_nxt_s = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            edge_nxt_s[p*DATA_W +: DATA_W] =
                (edge_r[p*DATA_W +: DATA_W] & ~({DATA_W{wr_edge_s[p]}} & bus.data_store))
                | new_edge_s[p*DATA_W +: DATA_W];
        end
    end

    // OUT, IRQ_EN and EDGE registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r    <= '0;
            irq_en_r <= '0;
            edge_r   <= '0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (wr_out_s[p]) begin
                    out_r[p*DATA_W +: DATA_W] <= bus.data_store;
                end
                if (wr_irq_en_s[p]) begin
                    irq_en_r[p*DATA_W +: DATA_W] <= bus.data_store;
                end
            end
            edge_r <= edge_nxt_s;
        end
    end

    // Aggregated interrupt, registered one cycle behind EDGE & IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(edge_r & irq_en_r);
        end
    end

    // Per-port read mux on the register offset
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            port_rd_s[p] = '0;
            case (ld_reg_s)
                REG_OUT:    port_rd_s[p] = out_r[p*DATA_W +: DATA_W];
                REG_IN:     port_rd_s[p] = in_s[p*DATA_W +: DATA_W];
                REG_EDGE:   port_rd_s[p] = edge_r[p*DATA_W +: DATA_W];
                REG_IRQ_EN: port_rd_s[p] = irq_en_r[p*DATA_W +: DATA_W];
                default:    port_rd_s[p] = '0;
            endcase
        end
    end

    // Combinational load data: OR of the selected port (select is one-hot,
    // all zero on a miss or when no load is requested)
    always_comb begin
        data_load_s = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            data_load_s = data_load_s | ({DATA_W{ld_sel_s[p]}} & port_rd_s[p]);
        end
    end

    assign bus.data_load = data_load_s;
    assign io_output     = out_r;
    assign irq           = irq_r;

endmodule

// File: tb/tb_io_mmio_bank.sv
// -----------------------------------------------------------------------------
// tb_io_mmio_bank
// Directed self-checking bench for io_mmio_bank with default parameters.
// A second instance built with EDGE_MODE=2 shares the same stimulus so that
// falling-edge capture can be compared against the rising-only build.
// -----------------------------------------------------------------------------
module tb_io_mmio_bank;

    logic        clk;
    logic        rst_n;
    logic [15:0] io_input;
    logic [15:0] io_output;
    logic [15:0] io_output2;
    logic        irq;
    logic        irq2;

    int n_checks = 0;
    int n_errors = 0;

    io_mmio_bank_if #(.ADDR_W(10), .DATA_W(8)) bif ();
    io_mmio_bank_if #(.ADDR_W(10), .DATA_W(8)) bif2 ();

    assign bif2.en_store   = bif.en_store;
    assign bif2.addr_store = bif.addr_store;
    assign bif2.data_store = bif.data_store;
    assign bif2.en_load    = bif.en_load;
    assign bif2.addr_load  = bif.addr_load;

    io_mmio_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bif.slave),
        .io_input  (io_input),
        .io_output (io_output),
        .irq       (irq)
    );

    io_mmio_bank #(.EDGE_MODE(2)) dut_both (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bif2.slave),
        .io_input  (io_input),
        .io_output (io_output2),
        .irq       (irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        io_input        = 16'h0000;
        bif.en_store    = 1'b0;
        bif.addr_store  = 10'h000;
        bif.data_store  = 8'h00;
        bif.en_load     = 1'b0;
        bif.addr_load   = 10'h000;

        // Reset state
        #12;
        bif.en_load   = 1'b1;
        bif.addr_load = 10'h3F0;
        #1;
        chk("rst_io_output", 32'(io_output), 32'h0000);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_load_out0", 32'(bif.data_load), 32'h00);
        tick();
        rst_n = 1'b1;

        // OUT0 write and readback
        bif.en_store   = 1'b1;
        bif.addr_store = 10'h3F0;
        bif.data_store = 8'hA5;
        tick();
        bif.en_store = 1'b0;
        #1;
        chk("out0_io_output", 32'(io_output), 32'h00A5);
        chk("out0_load", 32'(bif.data_load), 32'hA5);

        // Store and load to the same register in one cycle reads the old value
        bif.en_store   = 1'b1;
        bif.addr_store = 10'h3F4;
        bif.data_store = 8'h5A;
        bif.addr_load  = 10'h3F4;
        #1;
        chk("same_cycle_load_old", 32'(bif.data_load), 32'h00);
        chk("same_cycle_mem_en_store", 32'(bif.mem_en_store), 32'h0);
        chk("same_cycle_mem_en_load", 32'(bif.mem_en_load), 32'h0);
        tick();
        bif.en_store = 1'b0;
        #1;
        chk("out1_io_output", 32'(io_output), 32'h5AA5);
        chk("out1_load_new", 32'(bif.data_load), 32'h5A);

        // Out-of-window store and loads fall back to memory
        bif.en_store   = 1'b1;
        bif.addr_store = 10'h010;
        bif.data_store = 8'h33;
        #1;
        chk("oow_mem_en_store", 32'(bif.mem_en_store), 32'h1);
        tick();
        bif.en_store = 1'b0;
        #1;
        chk("oow_io_output_unchanged", 32'(io_output), 32'h5AA5);
        bif.addr_load = 10'h3F8;
        #1;
        chk("oow_above_mem_en_load", 32'(bif.mem_en_load), 32'h1);
        chk("oow_above_data_load", 32'(bif.data_load), 32'h00);
        bif.addr_load = 10'h3EF;
        #1;
        chk("oow_below_mem_en_load", 32'(bif.mem_en_load), 32'h1);
        bif.addr_load = 10'h3F7;
        #1;
        chk("last_word_mem_en_load", 32'(bif.mem_en_load), 32'h0);
        bif.en_load   = 1'b0;
        bif.addr_load = 10'h3F0;
        #1;
        chk("no_load_data_zero", 32'(bif.data_load), 32'h00);
        chk("no_load_mem_en_load", 32'(bif.mem_en_load), 32'h0);
        bif.en_load = 1'b1;

        // Edge capture and interrupt timing on port 0
        bif.en_store   = 1'b1;
        bif.addr_store = 10'h3F3;
        bif.data_store = 8'h01;
        tick();
        bif.en_store  = 1'b0;
        io_input      = 16'h0081;
        bif.addr_load = 10'h3F1;
        #1;
        chk("in0_before", 32'(bif.data_load), 32'h00);
        tick();
        chk("in0_after1", 32'(bif.data_load), 32'h00);
        tick();
        chk("in0_after2", 32'(bif.data_load), 32'h81);
        bif.addr_load = 10'h3F2;
        #1;
        chk("edge0_after2", 32'(bif.data_load), 32'h00);
        tick();
        chk("edge0_after3", 32'(bif.data_load), 32'h81);
        chk("irq_after3", 32'(irq), 32'h0);
        tick();
        chk("irq_after4", 32'(irq), 32'h1);

        // W1C of bit0; irq drops one cycle after the clear lands
        bif.en_store   = 1'b1;
        bif.addr_store = 10'h3F2;
        bif.data_store = 8'h01;
        tick();
        bif.en_store = 1'b0;
        #1;
        chk("edge0_w1c", 32'(bif.data_load), 32'h80);
        chk("irq_still_set", 32'(irq), 32'h1);
        tick();
        chk("irq_cleared", 32'(irq), 32'h0);

        // Falling edge: ignored in rising mode, captured in both-edge mode
        io_input = 16'h0080;
        tick();
        tick();
        tick();
        chk("edge0_fall_rising_mode", 32'(bif.data_load), 32'h80);
        chk("edge0_fall_both_mode", 32'(bif2.data_load), 32'h81);
        chk("irq_after_fall", 32'(irq), 32'h0);

        // Set wins over a same-cycle clear; bit7 clears normally
        io_input = 16'h0081;
        tick();
        tick();
        bif.en_store   = 1'b1;
        bif.addr_store = 10'h3F2;
        bif.data_store = 8'h81;
        #1;
        chk("edge0_pre_w1c_race", 32'(bif.data_load), 32'h80);
        tick();
        bif.en_store = 1'b0;
        #1;
        chk("edge0_set_wins", 32'(bif.data_load), 32'h01);
        tick();
        chk("irq_after_set_wins", 32'(irq), 32'h1);

        // Writes to IN are ignored and stay inside the window
        bif.en_store   = 1'b1;
        bif.addr_store = 10'h3F1;
        bif.data_store = 8'hFF;
        #1;
        chk("in_write_mem_en_store", 32'(bif.mem_en_store), 32'h0);
        tick();
        bif.en_store  = 1'b0;
        bif.addr_load = 10'h3F1;
        #1;
        chk("in_write_ignored", 32'(bif.data_load), 32'h81);
        chk("in_write_io_output", 32'(io_output), 32'h5AA5);

        // Mid-cycle reset clears outputs immediately
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_io_output", 32'(io_output), 32'h0000);
        chk("midrst_irq", 32'(irq), 32'h0);
        tick();
        rst_n         = 1'b1;
        bif.addr_load = 10'h3F0;
        #1;
        chk("post_rst_out0", 32'(bif.data_load), 32'h00);
        bif.addr_load = 10'h3F3;
        #1;
        chk("post_rst_irq_en0", 32'(bif.data_load), 32'h00);
        bif.addr_load = 10'h3F2;
        #1;
        chk("post_rst_edge0", 32'(bif.data_load), 32'h00);

        // Input held high through reset counts as a rising edge
        tick();
        tick();
        chk("held_high_edge_after2", 32'(bif.data_load), 32'h00);
        tick();
        chk("held_high_edge_after3", 32'(bif.data_load), 32'h81);
        chk("held_high_irq_masked", 32'(irq), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
